inj_ni: RTL and testbench

INJ_NI -- requirements
Module: inj_ni

---
 rtl/inj_ni.sv | 225 ++++++++++++++++++++++
 tb/tb_inj_ni.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inj_ni.sv
// -----------------------------------------------------------------------------
// inj_ni -- network-interface injection engine for router port 0.
//
// Packet requests ({dst, len}) are queued in a small FIFO. A three-state FSM
// (IDLE / HEAD / BODY) takes one request at a time and turns it into a
// sequence of flits. One flit at most is presented per inject_en strobe. The
// head flit picks a virtual channel round-robin among the VCs whose port-0
// buffer is free, and every later flit of the same packet stays on that VC.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   req_valid   in   packet request offered
//   req_dst     in   [13:0] destination router id
//   req_len     in   [3:0]  packet length in flits (0 means 1)
//   req_ready   out  request FIFO not full
//   inject_en   in   one-cycle strobe marking a flit slot
//   can_inject  in   [MAXVC-1:0] per-VC buffer-free flags of router port 0
//   inj_flit    out  [21:0] {full, vc[3:0], head, tail, 1'b0, dst[13:0]};
//                    all-zero means "no flit"
//   pkts_sent   out  [15:0] count of tail flits emitted (wraps)
//   idle        out  FIFO empty and FSM in IDLE
// -----------------------------------------------------------------------------
module inj_ni #(
    parameter int MAXVC  = 4,   // 1..16
    parameter int QDEPTH = 4    // power of two, 2..16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [13:0]      req_dst,
    input  logic [3:0]       req_len,
    output logic             req_ready,
    input  logic             inject_en,
    input  logic [MAXVC-1:0] can_inject,
    output logic [21:0]      inj_flit,
    output logic [15:0]      pkts_sent,
    output logic             idle
);

    localparam int PW  = $clog2(QDEPTH);
    localparam int CW  = PW + 1;
    localparam int VCW = (MAXVC > 1) ? $clog2(MAXVC) : 1;

    localparam logic [3:0]    LAST_VC_RST = 4'(MAXVC - 1);
    localparam logic [CW-1:0] FULL_CNT    = CW'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [17:0]   fifo_mem [QDEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    logic          push;
    logic          pop;
    logic          fifo_nempty;

    logic [13:0]   head_dst;
    logic [3:0]    head_len;
    logic [3:0]    head_rem;

    // ------------------------------------------------------------------
    // FSM state and per-packet context
    // ------------------------------------------------------------------
    state_t        state_q;
    logic [13:0]   cur_dst_q;
    logic [3:0]    cur_rem_q;
    logic [3:0]    cur_vc_q;
    logic [3:0]    last_vc_q;
    logic [21:0]   flit_q;
    logic [15:0]   pkts_q;

    // Round-robin arbitration result for the head flit
    logic          rr_found_d;
    logic [3:0]    rr_vc_d;

    logic          head_emit;
    logic          body_emit;
    logic          is_tail;
    logic          tail_emit;
    logic          load_next;

    // ready depends only on the pre-edge count: a pop in the same cycle
    // does not open a slot for a push when the FIFO is full.
    assign req_ready   = (count_q != FULL_CNT);
    assign fifo_nempty = (count_q != '0);
    assign push        = req_valid && req_ready;

    assign head_dst = fifo_mem[rd_ptr_q][17:4];
    assign head_len = fifo_mem[rd_ptr_q][3:0];
    assign head_rem = (head_len == 4'd0) ? 4'd1 : head_len;

    // Search starts at last_vc+1 and wraps modulo MAXVC; the first free VC
    // found wins.
    always_comb begin
        rr_found_d = 1'b0;
        rr_vc_d    = '0;
        for (int i = 1; i <= MAXVC; i++) begin
            if (!rr_found_d && can_inject[VCW'((int'(last_vc_q) + i) % MAXVC)]) begin
                rr_found_d = 1'b1;
                rr_vc_d    = 4'((int'(last_vc_q) + i) % MAXVC);
            end
        end
    end

    assign head_emit = (state_q == HEAD) && inject_en && rr_found_d;
    // A body flit may only go out on the VC chosen by its head flit.
    assign body_emit = (state_q == BODY) && inject_en && can_inject[cur_vc_q[VCW-1:0]];
    assign is_tail   = (cur_rem_q == 4'd1);
    assign tail_emit = (head_emit || body_emit) && is_tail;

    // A new request is latched when idle, or straight after a tail flit so
    // that back-to-back packets do not lose a slot passing through IDLE.
    assign load_next = fifo_nempty && ((state_q == IDLE) || tail_emit);
    assign pop       = load_next;

    // ------------------------------------------------------------------
    // FIFO data (no reset: contents are only read when count_q says valid)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {req_dst, req_len};
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy (pointers wrap naturally, QDEPTH is 2^n)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Injection FSM with registered flit output and packet counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_dst_q <= '0;
            cur_rem_q <= '0;
            cur_vc_q  <= '0;
            last_vc_q <= LAST_VC_RST;
            flit_q    <= '0;
            pkts_q    <= '0;
        end else begin
            // The flit word is a one-cycle pulse; it clears unless rewritten.
            flit_q <= '0;

            if (load_next) begin
                cur_dst_q <= head_dst;
                cur_rem_q <= head_rem;
            end

            case (state_q)
                IDLE: begin
                    // inject_en is deliberately ignored here; nothing is owed
                    // to a strobe that arrived before a packet was ready.
                    if (fifo_nempty) begin
                        state_q <= HEAD;
                    end
                end

                HEAD: begin
                    if (head_emit) begin
                        last_vc_q <= rr_vc_d;
                        cur_vc_q  <= rr_vc_d;
                        flit_q    <= {1'b1, rr_vc_d, 1'b1, is_tail, 1'b0, cur_dst_q};
                        if (is_tail) begin
                            pkts_q  <= pkts_q + 16'd1;
                            state_q <= fifo_nempty ? HEAD : IDLE;
                        end else begin
                            cur_rem_q <= cur_rem_q - 4'd1;
                            state_q   <= BODY;
                        end
                    end
                end

                BODY: begin
                    if (body_emit) begin
                        flit_q <= {1'b1, cur_vc_q, 1'b0, is_tail, 1'b0, cur_dst_q};
                        if (is_tail) begin
                            pkts_q  <= pkts_q + 16'd1;
                            state_q <= fifo_nempty ? HEAD : IDLE;
                        end else begin
                            cur_rem_q <= cur_rem_q - 4'd1;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign inj_flit  = flit_q;
    assign pkts_sent = pkts_q;
    assign idle      = !fifo_nempty && (state_q == IDLE);

endmodule

// File: tb/tb_inj_ni.sv
// -----------------------------------------------------------------------------
// tb_inj_ni -- directed self-checking bench for inj_ni.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_inj_ni;

    localparam int MAXVC  = 4;
    localparam int QDEPTH = 4;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic [13:0]      req_dst;
    logic [3:0]       req_len;
    logic             req_ready;
    logic             inject_en;
    logic [MAXVC-1:0] can_inject;
    logic [21:0]      inj_flit;
    logic [15:0]      pkts_sent;
    logic             idle;

    int n_checks;
    int n_fail;

    inj_ni #(
        .MAXVC  (MAXVC),
        .QDEPTH (QDEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_dst    (req_dst),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .inject_en  (inject_en),
        .can_inject (can_inject),
        .inj_flit   (inj_flit),
        .pkts_sent  (pkts_sent),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold reset for two cycles, release on a falling edge.
    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = 1'b0;
        inject_en  = 1'b0;
        can_inject = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer one request for one cycle (FIFO known to have room).
    task automatic push_req(input logic [13:0] d, input logic [3:0] l);
        req_valid = 1'b1;
        req_dst   = d;
        req_len   = l;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_dst    = 14'd7;
        req_len    = 4'd1;
        inject_en  = 1'b1;
        can_inject = '1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (inj_flit !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_flit: got %h expected %h", inj_flit, 22'h0);
        end
        n_checks++;
        if (pkts_sent !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_pkts: got %h expected %h", pkts_sent, 16'h0);
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
        n_checks++;
        if (idle !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle: got %b expected 1", idle);
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        inject_en = 1'b0;
        can_inject = '0;
    endtask

    // dst=12 len=1 on all-free VCs: single flit on VC0, head and tail set.
    task automatic test_single();
        do_reset();
        push_req(14'd12, 4'd1);
        inject_en  = 1'b1;
        can_inject = 4'b1111;
        @(negedge clk);
        // This edge only moved IDLE->HEAD; the strobe must not produce a flit.
        n_checks++;
        if (inj_flit !== 22'h0) begin
            n_fail++;
            $display("FAIL single_latency: got %h expected %h", inj_flit, 22'h0);
        end
        n_checks++;
        if (idle !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy: idle got %b expected 0", idle);
        end
        @(negedge clk);
        inject_en = 1'b0;
        n_checks++;
        if (inj_flit !== 22'h21800C) begin
            n_fail++;
            $display("FAIL single_flit: got %h expected %h", inj_flit, 22'h21800C);
        end
        n_checks++;
        if (pkts_sent !== 16'd1) begin
            n_fail++;
            $display("FAIL single_pkts: got %0d expected 1", pkts_sent);
        end
        @(negedge clk);
        n_checks++;
        if (inj_flit !== 22'h0) begin
            n_fail++;
            $display("FAIL single_pulse: got %h expected %h", inj_flit, 22'h0);
        end
        n_checks++;
        if (idle !== 1'b1) begin
            n_fail++;
            $display("FAIL single_idle: got %b expected 1", idle);
        end
    endtask

    // dst=5 len=3 with only VC2 free; body stalls while VC2 is busy even
    // if other VCs are free.
    task automatic test_stall();
        logic [3:0] stall_mask [4];
        stall_mask[0] = 4'b0000;
        stall_mask[1] = 4'b0000;
        stall_mask[2] = 4'b0000;
        stall_mask[3] = 4'b1011;
        do_reset();
        can_inject = 4'b0100;
        push_req(14'd5, 4'd3);
        @(negedge clk);
        inject_en = 1'b1;
        @(negedge clk);
        inject_en = 1'b0;
        n_checks++;
        if (inj_flit !== 22'h250005) begin
            n_fail++;
            $display("FAIL stall_head: got %h expected %h", inj_flit, 22'h250005);
        end
        n_checks++;
        if (pkts_sent !== 16'd0) begin
            n_fail++;
            $display("FAIL stall_pkts_mid: got %0d expected 0", pkts_sent);
        end
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            can_inject = stall_mask[s];
            inject_en  = 1'b1;
            @(negedge clk);
            inject_en = 1'b0;
            n_checks++;
            if (inj_flit !== 22'h0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got %h expected %h", s, inj_flit, 22'h0);
            end
            @(negedge clk);
        end
        can_inject = 4'b0100;
        inject_en  = 1'b1;
        @(negedge clk);
        inject_en = 1'b0;
        n_checks++;
        if (inj_flit !== 22'h240005) begin
            n_fail++;
            $display("FAIL stall_body: got %h expected %h", inj_flit, 22'h240005);
        end
        @(negedge clk);
        inject_en = 1'b1;
        @(negedge clk);
        inject_en = 1'b0;
        n_checks++;
        if (inj_flit !== 22'h248005) begin
            n_fail++;
            $display("FAIL stall_tail: got %h expected %h", inj_flit, 22'h248005);
        end
        n_checks++;
        if (pkts_sent !== 16'd1) begin
            n_fail++;
            $display("FAIL stall_pkts: got %0d expected 1", pkts_sent);
        end
        @(negedge clk);
        n_checks++;
        if (idle !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_idle: got %b expected 1", idle);
        end
    endtask

    // Five single-flit packets, all VCs free: VCs 0,1,2,3 then wrap to 0.
    task automatic test_rr();
        int n;
        do_reset();
        can_inject = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            push_req(14'(i + 1), 4'd1);
        end
        inject_en = 1'b1;
        n = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (inj_flit[21]) begin
                n_checks++;
                if (inj_flit[20:17] !== 4'(n % 4)) begin
                    n_fail++;
                    $display("FAIL rr_vc%0d: got %0d expected %0d", n, inj_flit[20:17], n % 4);
                end
                n_checks++;
                if (inj_flit[16:15] !== 2'b11 || inj_flit[13:0] !== 14'(n + 1)) begin
                    n_fail++;
                    $display("FAIL rr_word%0d: got %h expected head/tail=11 dst=%0d", n, inj_flit, n + 1);
                end
                n++;
            end
        end
        inject_en = 1'b0;
        n_checks++;
        if (n !== 5) begin
            n_fail++;
            $display("FAIL rr_count: got %0d flits expected 5", n);
        end
        n_checks++;
        if (idle !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_idle: got %b expected 1", idle);
        end
        n_checks++;
        if (pkts_sent !== 16'd5) begin
            n_fail++;
            $display("FAIL rr_pkts: got %0d expected 5", pkts_sent);
        end
    endtask

    // Flood requests with no strobes. The FSM takes the first request into
    // HEAD, so the FIFO fills after QDEPTH+1 accepts and the next one is
    // refused and never emitted.
    task automatic test_full();
        int acc;
        int n;
        do_reset();
        acc = 0;
        for (int i = 0; i < QDEPTH + 2; i++) begin
            req_valid = 1'b1;
            req_dst   = 14'(100 + i);
            req_len   = 4'd1;
            if (req_ready) acc++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        n_checks++;
        if (acc !== QDEPTH + 1) begin
            n_fail++;
            $display("FAIL full_accepts: got %0d expected %0d", acc, QDEPTH + 1);
        end
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: got %b expected 0", req_ready);
        end
        can_inject = 4'b1111;
        inject_en  = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (inj_flit[21]) begin
                n_checks++;
                if (inj_flit[13:0] !== 14'(100 + n)) begin
                    n_fail++;
                    $display("FAIL full_dst%0d: got %0d expected %0d", n, inj_flit[13:0], 100 + n);
                end
                n++;
            end
        end
        inject_en = 1'b0;
        n_checks++;
        if (n !== QDEPTH + 1) begin
            n_fail++;
            $display("FAIL full_drain: got %0d flits expected %0d", n, QDEPTH + 1);
        end
        n_checks++;
        if (req_ready !== 1'b1 || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL full_after: ready=%b idle=%b expected 1 1", req_ready, idle);
        end
    endtask

    // Reset right after the head flit of a len=4 packet with another
    // request queued: everything is discarded.
    task automatic test_reset_mid();
        int n;
        do_reset();
        can_inject = 4'b1111;
        push_req(14'd9, 4'd4);
        push_req(14'd10, 4'd2);
        inject_en = 1'b1;
        @(negedge clk);
        inject_en = 1'b0;
        n_checks++;
        if (inj_flit !== 22'h210009) begin
            n_fail++;
            $display("FAIL rstmid_head: got %h expected %h", inj_flit, 22'h210009);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (inj_flit !== 22'h0) begin
            n_fail++;
            $display("FAIL rstmid_flit: got %h expected %h", inj_flit, 22'h0);
        end
        n_checks++;
        if (idle !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_idle: got %b expected 1", idle);
        end
        @(negedge clk);
        rst       = 1'b0;
        inject_en = 1'b1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (inj_flit !== 22'h0) n++;
        end
        inject_en = 1'b0;
        n_checks++;
        if (n !== 0) begin
            n_fail++;
            $display("FAIL rstmid_noflit: got %0d flits expected 0", n);
        end
        n_checks++;
        if (pkts_sent !== 16'd0 || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_after: pkts=%0d idle=%b expected 0 1", pkts_sent, idle);
        end
    endtask

    // 65535 single-flit packets bring the counter to 0xFFFF; one more wraps.
    task automatic test_wrap();
        int acc;
        int cyc;
        bit done;
        do_reset();
        can_inject = 4'b1111;
        inject_en  = 1'b1;
        req_len    = 4'd1;
        acc = 0;
        cyc = 0;
        while (acc < 65535 && cyc < 70000) begin
            req_valid = 1'b1;
            req_dst   = 14'(acc);
            if (req_ready) acc++;
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        n_checks++;
        if (acc !== 65535) begin
            n_fail++;
            $display("FAIL wrap_timeout: accepted %0d expected 65535", acc);
        end
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (idle) done = 1'b1;
        end
        n_checks++;
        if (pkts_sent !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_ffff: got %h expected %h", pkts_sent, 16'hFFFF);
        end
        push_req(14'd3, 4'd1);
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (idle) done = 1'b1;
        end
        inject_en = 1'b0;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_idle: got %b expected 1", done);
        end
        n_checks++;
        if (pkts_sent !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_zero: got %h expected %h", pkts_sent, 16'h0000);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_dst    = '0;
        req_len    = '0;
        inject_en  = 1'b0;
        can_inject = '0;

        test_reset();
        test_single();
        test_stall();
        test_rr();
        test_full();
        test_reset_mid();
        test_wrap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
